// File: rtl/add_digit_serial.sv
// Digit-serial add/subtract unit: DIGIT bits per clock over WIDTH/DIGIT cycles,
// with a start/busy/done handshake, carry-out and signed-overflow flags.
module add_digit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] ra, rb, psum, psum_next;
    logic             rc;
    logic [CW-1:0]    cnt;
    logic             amsb, bmsb;
    logic [DIGIT:0]   dsum;
    logic             accept, last;

    always_comb begin
        dsum      = {1'b0, ra[DIGIT-1:0]} + {1'b0, rb[DIGIT-1:0]} + (DIGIT+1)'(rc);
        // Shift form keeps DIGIT == WIDTH legal (no zero-width slices).
        psum_next = (psum >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        accept    = (state == IDLE) && start;
        last      = (state == RUN) && (cnt == LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            rc   <= 1'b0;
            psum <= '0;
            cnt  <= '0;
            amsb <= 1'b0;
            bmsb <= 1'b0;
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ra   <= a;
                rb   <= sub ? ~b : b;
                rc   <= sub ? ~cin : cin;
                psum <= '0;
                cnt  <= '0;
                amsb <= a[WIDTH-1];
                bmsb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            end else if (state == RUN) begin
                ra   <= ra >> DIGIT;
                rb   <= rb >> DIGIT;
                rc   <= dsum[DIGIT];
                psum <= psum_next;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    s    <= psum_next;
                    cout <= dsum[DIGIT];
                    ovf  <= (amsb == bmsb) && (psum_next[WIDTH-1] != amsb);
                    done <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_add_digit_serial.sv
// Directed and reference-model checks for add_digit_serial at 8/2, 16/1 and 16/16.
module tb_add_digit_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start;
    logic        sub, cin;
    logic [15:0] ta, tb_;
    logic [2:0]  busy, done, cout, ovf;
    logic [7:0]  s8;
    logic [15:0] s16a, s16b;

    int total = 0;
    int bad   = 0;

    add_digit_serial #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub), .a(ta[7:0]), .b(tb_[7:0]),
        .cin(cin), .busy(busy[0]), .done(done[0]), .s(s8), .cout(cout[0]), .ovf(ovf[0])
    );

    add_digit_serial #(.WIDTH(16), .DIGIT(1)) dut16a (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub), .a(ta), .b(tb_),
        .cin(cin), .busy(busy[1]), .done(done[1]), .s(s16a), .cout(cout[1]), .ovf(ovf[1])
    );

    add_digit_serial #(.WIDTH(16), .DIGIT(16)) dut16b (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub), .a(ta), .b(tb_),
        .cin(cin), .busy(busy[2]), .done(done[2]), .s(s16b), .cout(cout[2]), .ovf(ovf[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] res(input int d);
        case (d)
            0:       return {cout[0], ovf[0], 8'h00, s8};
            1:       return {cout[1], ovf[1], s16a};
            default: return {cout[2], ovf[2], s16b};
        endcase
    endfunction

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic start_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                            input logic ci, input logic sb);
        ta = av; tb_ = bv; cin = ci; sub = sb;
        start[d] = 1'b1;
        @(negedge clk);
        start = '0;
    endtask

    task automatic wait_done(input int d, input int c0, output int cyc, output int bc);
        cyc = c0;
        bc  = 0;
        while (!done[d] && cyc < 100) begin
            if (busy[d]) bc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc, bc, seen;
        logic [15:0] av, bv;
        logic ci, sb;
        int sa, sbv, v, full, nlat;
        logic [17:0] expv;

        rst_n = 1'b0; start = '0; ta = '0; tb_ = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("reset_idle", {busy[0], done[0], cout[0], ovf[0], s8}, 32'h0);
        end

        start_op(0, 16'h7F, 16'h01, 1'b0, 1'b0);
        wait_done(0, 1, cyc, bc);
        chk("lat_7f", cyc, 5);
        chk("busy_7f", bc, 4);
        chk("res_7f", res(0), {1'b0, 1'b1, 16'h0080});
        @(negedge clk);
        chk("done_pulse", done[0], 0);
        chk("hold_7f", res(0), {1'b0, 1'b1, 16'h0080});

        start_op(0, 16'hFF, 16'h01, 1'b1, 1'b0);
        wait_done(0, 1, cyc, bc);
        chk("res_ff", res(0), {1'b1, 1'b0, 16'h0001});

        start_op(0, 16'h05, 16'h07, 1'b0, 1'b1);
        wait_done(0, 1, cyc, bc);
        chk("res_sub_borrow", res(0), {1'b0, 1'b0, 16'h00FE});

        start_op(0, 16'h07, 16'h05, 1'b1, 1'b1);
        wait_done(0, 1, cyc, bc);
        chk("res_sub_bin", res(0), {1'b1, 1'b0, 16'h0001});

        start_op(0, 16'h80, 16'h01, 1'b0, 1'b1);
        wait_done(0, 1, cyc, bc);
        chk("res_sub_ovf", res(0), {1'b1, 1'b1, 16'h007F});

        start_op(0, 16'h10, 16'h20, 1'b0, 1'b0);
        @(negedge clk);
        ta = 16'h55; tb_ = 16'h11; sub = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        start = '0;
        chk("busy_mid", busy[0], 1);
        wait_done(0, 3, cyc, bc);
        chk("lat_ignored", cyc, 5);
        chk("res_ignored", res(0), {1'b0, 1'b0, 16'h0030});

        start_op(0, 16'h40, 16'h40, 1'b0, 1'b0);
        wait_done(0, 1, cyc, bc);
        chk("lat_b2b", cyc, 5);
        chk("res_b2b", res(0), {1'b0, 1'b1, 16'h0080});

        start_op(0, 16'h12, 16'h34, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_abort", {busy[0], done[0], cout[0], ovf[0], s8}, 32'h0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done[0]) seen = 1;
        end
        chk("no_done_after_rst", seen, 0);
        start_op(0, 16'h12, 16'h34, 1'b0, 1'b0);
        wait_done(0, 1, cyc, bc);
        chk("lat_after_rst", cyc, 5);
        chk("res_after_rst", res(0), {1'b0, 1'b0, 16'h0046});

        for (int d = 1; d <= 2; d++) begin
            nlat = (d == 1) ? 17 : 2;
            for (int i = 0; i < 1000; i++) begin
                av  = 16'($urandom);
                bv  = 16'($urandom);
                ci  = 1'($urandom_range(0, 1));
                sb  = 1'($urandom_range(0, 1));
                sa  = int'($signed(av));
                sbv = int'($signed(bv));
                v    = sb ? (sa - sbv - int'(ci)) : (sa + sbv + int'(ci));
                full = sb ? (int'(av) + (65535 - int'(bv)) + (1 - int'(ci)))
                          : (int'(av) + int'(bv) + int'(ci));
                expv = {((full >> 16) & 1) != 0, (v > 32767) || (v < -32768), full[15:0]};
                start_op(d, av, bv, ci, sb);
                wait_done(d, 1, cyc, bc);
                chk(d == 1 ? "lat_16x1" : "lat_16x16", cyc, nlat);
                chk(d == 1 ? "res_16x1" : "res_16x16", res(d), expv);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
